// File: rtl/wb_stream_reader_ctrl_if.sv
// Wishbone B3 master bundle for the stream reader.
// master: drives adr/dat/sel/we/cyc/stb/cti/bte; slave: drives dat_i/ack/err/rty.
interface wb_stream_reader_ctrl_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic               wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
        output wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/wb_stream_reader_ctrl.sv
// Wishbone burst-read master streaming buf_size words from start_adr into a FIFO.
// Ports: wb_clk_i/wb_rst_ni, wbm (bus master), fifo_d/fifo_wr/fifo_cnt, config, busy/done/err.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_stream_reader_ctrl_if.master wbm,
    output logic [WB_DW-1:0]       fifo_d,
    output logic                   fifo_wr,
    input  logic [FIFO_AW:0]       fifo_cnt,
    input  logic                   enable,
    input  logic [WB_AW-1:0]       start_adr,
    input  logic [WB_AW-1:0]       buf_size,
    input  logic [WB_AW-1:0]       burst_size,
    input  logic                   continous,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int BPW   = WB_DW / 8;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_GAP
    } state_t;

    state_t           state;
    logic [WB_AW-1:0] idx;
    logic [WB_AW-1:0] beat;
    logic [WB_AW-1:0] len_q;
    logic [WB_AW-1:0] start_q;
    logic [WB_AW-1:0] size_q;
    logic             cont_q;
    logic             armed;
    logic             cyc;
    logic             stb;
    logic [2:0]       cti;

    logic [WB_AW-1:0] eff_burst;
    logic [WB_AW-1:0] rem;
    logic [WB_AW-1:0] len;
    logic [WB_AW-1:0] space;

    always_comb begin
        eff_burst = burst_size;
        if (burst_size == '0)
            eff_burst = WB_AW'(1);
        else if (burst_size > WB_AW'(MAX_BURST_LEN))
            eff_burst = WB_AW'(MAX_BURST_LEN);
        rem   = buf_size - idx;
        len   = (eff_burst < rem) ? eff_burst : rem;
        // An over-reported occupancy means no room rather than a wrapped huge space.
        space = '0;
        if (fifo_cnt < (FIFO_AW+1)'(DEPTH))
            space = WB_AW'(DEPTH) - WB_AW'(fifo_cnt);
    end

    // Address tracks idx directly so the beat after an ack shows the next word.
    assign wbm.wbm_adr_o = start_q + idx * WB_AW'(BPW);
    assign wbm.wbm_dat_o = '0;
    assign wbm.wbm_sel_o = {BPW{cyc}};
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_cyc_o = cyc;
    assign wbm.wbm_stb_o = stb;
    assign wbm.wbm_cti_o = cti;
    assign wbm.wbm_bte_o = 2'b00;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= S_IDLE;
            idx     <= '0;
            beat    <= '0;
            len_q   <= '0;
            start_q <= '0;
            size_q  <= '0;
            cont_q  <= 1'b0;
            armed   <= 1'b1;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            cti     <= 3'b000;
            fifo_d  <= '0;
            fifo_wr <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            fifo_wr <= 1'b0;
            done    <= 1'b0;
            if (!enable) begin
                armed <= 1'b1;
                err   <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (enable && buf_size != '0 && !err && armed)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!enable || idx >= buf_size) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (space >= len) begin
                        state   <= S_BURST;
                        cyc     <= 1'b1;
                        stb     <= 1'b1;
                        cti     <= (len == WB_AW'(1)) ? 3'b111 : 3'b010;
                        beat    <= '0;
                        len_q   <= len;
                        start_q <= start_adr;
                        size_q  <= buf_size;
                        cont_q  <= continous;
                    end
                end
                S_BURST: begin
                    if (wbm.wbm_err_i) begin
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        err   <= 1'b1;
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (wbm.wbm_rty_i) begin
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        state <= S_GAP;
                    end else if (wbm.wbm_ack_i) begin
                        fifo_d  <= wbm.wbm_dat_i;
                        fifo_wr <= 1'b1;
                        idx     <= idx + WB_AW'(1);
                        beat    <= beat + WB_AW'(1);
                        if (beat == len_q - WB_AW'(1)) begin
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            state <= S_GAP;
                        end else if (beat + WB_AW'(2) == len_q) begin
                            cti <= 3'b111;
                        end
                    end
                end
                S_GAP: begin
                    if (idx == size_q) begin
                        idx <= '0;
                        if (cont_q) begin
                            state <= S_WAIT;
                        end else begin
                            done  <= 1'b1;
                            armed <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (enable) begin
                        state <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Randomized scoreboard bench for wb_stream_reader_ctrl.
// A slave/FIFO model checks every bus beat and every FIFO write.
module tb_wb_stream_reader_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FAW = 4;
    localparam int MAXB = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stream_reader_ctrl_if #(.WB_AW(AW), .WB_DW(DW)) wb ();

    logic [DW-1:0] fifo_d;
    logic          fifo_wr;
    logic [FAW:0]  fifo_cnt;
    logic          enable;
    logic [AW-1:0] start_adr;
    logic [AW-1:0] buf_size;
    logic [AW-1:0] burst_size;
    logic          continous;
    logic          busy;
    logic          done;
    logic          err;

    wb_stream_reader_ctrl #(
        .WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW), .MAX_BURST_LEN(MAXB)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbm       (wb),
        .fifo_d    (fifo_d),
        .fifo_wr   (fifo_wr),
        .fifo_cnt  (fifo_cnt),
        .enable    (enable),
        .start_adr (start_adr),
        .buf_size  (buf_size),
        .burst_size(burst_size),
        .continous (continous),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model state: buffer word position, beats left in current burst.
    logic [DW-1:0] exp_q[$];
    int  m_idx = 0;
    int  m_rem = 0;
    int  m_beat = 0;
    int  m_eff = 1;
    bit  m_in = 0;
    int  done_seen = 0;
    int  words = 0;
    int  wait_pct = 0;
    bit  drain_en = 1;
    int  inj_kind = 0;
    int  inj_beat = 0;
    bit  err_chk = 0;

    function automatic int eff_of(logic [AW-1:0] b);
        if (b == 0) return 1;
        if (b > MAXB) return MAXB;
        return int'(b);
    endfunction

    // Slave, FIFO occupancy model and monitor, all acting on the falling edge.
    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] ea;
        wb.wbm_ack_i = 1'b0;
        wb.wbm_err_i = 1'b0;
        wb.wbm_rty_i = 1'b0;
        wb.wbm_dat_i = '0;
        fifo_cnt = '0;
        forever begin
            @(negedge clk);
            wb.wbm_ack_i = 1'b0;
            wb.wbm_err_i = 1'b0;
            wb.wbm_rty_i = 1'b0;
            if (!rst_n) continue;
            if (err_chk) begin
                chk("cyc_after_err", wb.wbm_cyc_o, 0);
                chk("err_flag", err, 1);
                err_chk = 0;
            end
            if (fifo_wr) begin
                if (exp_q.size() == 0) chk("fifo_wr_unexpected", 1, 0);
                else chk("fifo_d", fifo_d, exp_q.pop_front());
                fifo_cnt = fifo_cnt + 1'b1;
                chk("fifo_overflow", fifo_cnt <= DEPTH, 1);
            end
            if (drain_en && fifo_cnt > 0 && $urandom_range(1, 0) == 1)
                fifo_cnt = fifo_cnt - 1'b1;
            if (done) done_seen++;
            if (!wb.wbm_cyc_o) begin
                m_in = 0;
            end else if (wb.wbm_stb_o) begin
                if (!m_in) begin
                    m_in = 1;
                    m_beat = 0;
                    m_rem = int'(buf_size) - m_idx;
                    if (m_eff < m_rem) m_rem = m_eff;
                    chk("space_at_burst", (DEPTH - int'(fifo_cnt)) >= m_rem, 1);
                end
                if ($urandom_range(99, 0) >= wait_pct) begin
                    m_beat++;
                    ea = start_adr + AW'(m_idx * (DW / 8));
                    chk("adr", wb.wbm_adr_o, ea);
                    chk("cti", wb.wbm_cti_o, (m_rem == 1) ? 7 : 2);
                    chk("sel_we_bte",
                        {wb.wbm_sel_o, wb.wbm_we_o, wb.wbm_bte_o},
                        {4'hf, 1'b0, 2'b00});
                    if (inj_kind != 0 && m_beat == inj_beat) begin
                        if (inj_kind == 1) begin
                            wb.wbm_rty_i = 1'b1;
                        end else begin
                            // ack alongside err: err must win
                            wb.wbm_err_i = 1'b1;
                            wb.wbm_ack_i = 1'b1;
                            m_idx = 0;
                            err_chk = 1;
                        end
                        m_in = 0;
                        inj_kind = 0;
                    end else begin
                        d = $urandom;
                        wb.wbm_dat_i = d;
                        wb.wbm_ack_i = 1'b1;
                        exp_q.push_back(d);
                        words++;
                        m_idx++;
                        m_rem--;
                        if (m_rem == 0) m_in = 0;
                        if (m_idx == int'(buf_size)) m_idx = 0;
                    end
                end
            end
        end
    end

    task automatic start_run(logic [AW-1:0] sa, logic [AW-1:0] n,
                             logic [AW-1:0] b, bit c, int wp,
                             int ik, int ib);
        start_adr = sa;
        buf_size = n;
        burst_size = b;
        continous = c;
        wait_pct = wp;
        inj_kind = ik;
        inj_beat = ib;
        m_eff = eff_of(b);
        m_idx = 0;
        m_in = 0;
        done_seen = 0;
        words = 0;
        enable = 1'b1;
    endtask

    task automatic wait_done(string tag, int n);
        for (int i = 0; i < 20000 && done_seen == 0; i++) tick(1);
        tick(4);
        chk({tag, "_idle_after_done"}, busy, 0);
        enable = 1'b0;
        tick(2);
        chk({tag, "_words"}, words, n);
        chk({tag, "_done_pulses"}, done_seen, 1);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        enable = 1'b0;
        start_adr = '0;
        buf_size = '0;
        burst_size = '0;
        continous = 1'b0;
        tick(2);
        chk("rst_outputs",
            {busy, done, err, fifo_wr, wb.wbm_cyc_o, wb.wbm_stb_o,
             wb.wbm_cti_o, wb.wbm_sel_o, wb.wbm_we_o},
            '0);
        chk("rst_adr", wb.wbm_adr_o, 0);
        chk("rst_fifo_d", fifo_d, 0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_no_enable", busy, 0);

        // two full bursts, slave acks every cycle
        start_run(32'h1000, 8, 4, 0, 0, 0, 0);
        wait_done("t1", 8);

        // short tail burst
        start_run(32'h1000, 6, 4, 0, 0, 0, 0);
        wait_done("t2", 6);

        // FIFO nearly full holds the burst back
        drain_en = 0;
        fifo_cnt = 14;
        start_run(32'h1000, 4, 4, 0, 0, 0, 0);
        tick(20);
        chk("stall_no_cyc", wb.wbm_cyc_o, 0);
        chk("stall_busy", busy, 1);
        fifo_cnt = 12;
        for (int i = 0; i < 2 && !wb.wbm_cyc_o; i++) tick(1);
        chk("stall_release_cyc", wb.wbm_cyc_o, 1);
        wait_done("t3", 4);
        drain_en = 1;

        // continuous wrap, then stop
        start_run(32'h1000, 4, 4, 1, 0, 0, 0);
        for (int i = 0; i < 20000 && words < 12; i++) tick(1);
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick(1);
        tick(2);
        chk("cont_stopped", busy, 0);
        chk("cont_no_done", done_seen, 0);
        chk("cont_whole_bursts", words % 4, 0);
        chk("cont_queue_empty", exp_q.size(), 0);

        // bus error on beat 2
        start_run(32'h2000, 8, 4, 0, 0, 2, 2);
        for (int i = 0; i < 2000 && !err; i++) tick(1);
        tick(2);
        chk("err_one_word", words, 1);
        tick(10);
        chk("err_blocks", {busy, wb.wbm_cyc_o}, 0);
        enable = 1'b0;
        tick(2);
        chk("err_cleared", err, 0);
        chk("err_queue_empty", exp_q.size(), 0);
        start_run(32'h2000, 8, 4, 0, 0, 0, 0);
        wait_done("t5", 8);

        // retry on beat 3
        start_run(32'h1000, 8, 4, 0, 0, 1, 3);
        wait_done("t6", 8);

        // reset in the middle of a burst
        start_run(32'h3000, 16, 16, 0, 0, 0, 0);
        for (int i = 0; i < 2000 && !wb.wbm_cyc_o; i++) tick(1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_burst",
            {wb.wbm_cyc_o, wb.wbm_stb_o, fifo_wr, busy}, 0);
        chk("rst_mid_adr", wb.wbm_adr_o, 0);
        enable = 1'b0;
        tick(2);
        exp_q.delete();
        m_in = 0;
        m_idx = 0;
        rst_n = 1'b1;
        tick(2);

        // randomized buffers, bursts, wait states and retries
        for (int r = 0; r < 25; r++) begin
            int n;
            int b;
            int ik;
            n = $urandom_range(40, 1);
            b = $urandom_range(20, 0);
            ik = ($urandom_range(2, 0) == 0) ? 1 : 0;
            start_run($urandom, n, b, 0, $urandom_range(50, 0),
                      ik, $urandom_range(2, 1));
            wait_done("rnd", n);
            inj_kind = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stream_reader_ctrl.md
Name: wb_stream_reader_ctrl

Overview:
Wishbone B3 burst-read master that streams a memory buffer into a local FIFO, i.e. the memory-to-stream counterpart of the stream-to-memory write controller.
- Reads buf_size words starting at start_adr, in linear bursts of burst_size beats.
- Pushes each returned word into the FIFO, issuing a burst only when the FIFO has room for the whole burst.
- Sits between the system Wishbone interconnect and a stream source FIFO.

Parameters:
WB_AW, 32, Wishbone address width
WB_DW, 32, Wishbone data width (byte-lane count WB_DW/8)
FIFO_AW, 4, FIFO address width; capacity = 2**FIFO_AW words; must be >0
MAX_BURST_LEN, 16, maximum beats per burst; burst_size is clamped to this

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous assert, active-low
wbm_adr_o  out  WB_AW  byte address
wbm_dat_o  out  WB_DW  tied 0 (read-only master)
wbm_sel_o  out  WB_DW/8  all ones while cyc, else 0
wbm_we_o  out  1  always 0
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  cycle type
wbm_bte_o  out  2  always 00
wbm_dat_i  in  WB_DW  read data
wbm_ack_i  in  1  beat acknowledge
wbm_err_i  in  1  error terminate
wbm_rty_i  in  1  retry terminate
fifo_d  out  WB_DW  write data to FIFO
fifo_wr  out  1  FIFO write strobe, one word per cycle high
fifo_cnt  in  FIFO_AW+1  current FIFO occupancy
enable  in  1  level; run while high
start_adr  in  WB_AW  buffer base byte address
buf_size  in  WB_AW  buffer length in words
burst_size  in  WB_AW  beats per burst
continous  in  1  1 = wrap to start_adr and keep reading
busy  out  1  high outside S_IDLE
done  out  1  one-cycle pulse when a non-continuous buffer completes
err  out  1  sticky; set on wbm_err_i, cleared when enable is low

Behaviour:
Reset:
- All outputs 0.
- State S_IDLE; word index idx = 0.
Sampling and address/length arithmetic:
- Config inputs are sampled at each burst start.
- eff_burst = clamp(burst_size, 1, MAX_BURST_LEN).
- len = min(eff_burst, buf_size - idx).
- wbm_adr_o = start_adr + idx*(WB_DW/8), modulo 2**WB_AW.
States:
- S_IDLE: go to S_WAIT when enable=1, buf_size!=0, err=0 and armed=1. armed is cleared on done and set again while enable=0.
- S_WAIT: when (2**FIFO_AW - fifo_cnt) >= len, go to S_BURST and assert cyc/stb next cycle. If enable=0, return to S_IDLE with idx=0.
- S_BURST:
  - cti = 010, or 111 on the last beat; len=1 gives 111 on the single beat.
  - Each cycle with ack=1 advances idx and beat count.
  - Address updates combinationally from idx so the next beat presents the new address.
  - After the last beat's ack, deassert cyc/stb that edge and go to S_GAP.
- S_GAP: one cycle so the final fifo_wr is reflected in fifo_cnt.
  - If idx == buf_size: with continous=1, set idx=0 and go to S_WAIT; with continous=0, pulse done and go to S_IDLE with idx=0.
  - Otherwise, go to S_WAIT if enable=1, else S_IDLE with idx=0.
FIFO write:
- On each ack, fifo_d <= wbm_dat_i and fifo_wr <= 1 at the next edge (latency 1).
- fifo_wr is high for exactly one cycle per ack, and never on err or rty.
Terminations:
- err during a burst: drop cyc/stb next edge, set err, go to S_IDLE with idx=0. No FIFO write for that beat.
- rty during a burst: drop cyc/stb, do not advance idx, go to S_GAP. The same address is reissued in a new burst.
- ack and err in the same cycle: err wins.
- enable falling mid-burst: the current burst completes, then the block goes to S_IDLE with idx=0.
Reset mid-burst: cyc/stb/fifo_wr go low immediately (asynchronous) and idx=0.
The FIFO never overflows: a burst is not issued unless space >= len.

Test Plan:
- start_adr=0x1000, buf_size=8, burst_size=4, continous=0, fifo_cnt=0, slave acks every cycle -> two bursts at 0x1000..0x100C (cti 010,010,010,111) and 0x1010..0x101C; 8 fifo_wr pulses carrying the slave data in order; one done pulse; busy returns to 0.
- buf_size=6, burst_size=4 -> bursts of 4 then 2 beats; second burst at 0x1010 with cti 010,111; done after 6 words.
- FIFO_AW=4, fifo_cnt=14, burst_size=4 -> stays in S_WAIT with cyc=0; drop fifo_cnt to 12 -> burst starts within 2 cycles.
- continous=1, buf_size=4, burst_size=4 -> the address after 0x100C is 0x1000; no done pulse; dropping enable ends the stream after the current burst.
- wbm_err_i on beat 2 of a 4-beat burst -> cyc=0 next cycle, err=1, exactly 1 fifo_wr; a new burst needs enable low then high.
- wbm_rty_i on beat 3 -> 2 words written; the next burst restarts at beat 3's address; total words at done = buf_size.
